// File: rtl/simon_iter_ctrl.sv
// Iterative SIMON64/96 engine: caches the expanded key schedule and runs two
// 64-bit blocks through one round per cycle behind valid/ready handshakes.
module simon_iter_ctrl #(
    parameter int unsigned ROUNDS = 42,
    parameter int unsigned WORD   = 32
) (
    input  logic         clk_100MHz,
    input  logic         reset,
    input  logic         frame_valid,
    output logic         frame_ready,
    input  logic [255:0] frame_data,
    input  logic         decrypt,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [127:0] result_data,
    output logic         busy
);

    localparam int unsigned IDX_W = $clog2(ROUNDS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] FIRST_EXP = IDX_W'(3);
    localparam logic [WORD-1:0]  KCONST = {{(WORD-2){1'b1}}, 2'b00};
    // z2 sequence, element 0 sits at bit 61
    localparam logic [63:0] Z2 =
        {2'b00, 62'b10101111011100000011010010011000101000010001111110010110110011};

    typedef enum logic [1:0] {
        IDLE,
        KEXP,
        RUN,
        DONE
    } state_t;

    state_t state;

    logic [95:0]      key_reg;
    logic             key_cached;
    logic             dec_mode;
    logic [WORD-1:0]  a_x, a_y, b_x, b_y;
    logic [WORD-1:0]  na_x, na_y, nb_x, nb_y;
    logic [WORD-1:0]  w0, w1, w2;
    logic [WORD-1:0]  knext;
    logic [IDX_W-1:0] kidx;
    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] rcnt;
    logic [WORD-1:0]  rk;
    logic             primed;
    logic [5:0]       zidx;
    logic             z_bit;
    logic             key_hit;
    logic             accept;
    logic             accept_new;
    logic             unused_hi;

    logic [WORD-1:0]  ktab [ROUNDS];

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned s);
        return (v << s) | (v >> (WORD - s));
    endfunction

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int unsigned s);
        return rol(v, WORD - s);
    endfunction

    function automatic logic [WORD-1:0] f_mix(input logic [WORD-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    assign unused_hi  = ^frame_data[255:224];
    assign key_hit    = key_cached && (frame_data[95:0] == key_reg);
    assign accept     = frame_valid && frame_ready && (state == IDLE);
    assign accept_new = accept && !key_hit;

    // w0..w2 hold k[i-3], k[i-2], k[i-1]; expansion never reads the table
    always_comb begin
        zidx  = 6'd61 - (6'(kidx) - 6'd3);
        z_bit = Z2[zidx];
        knext = KCONST ^ {{(WORD-1){1'b0}}, z_bit} ^ w0 ^ ror(w2, 3) ^ ror(w2, 4);
    end

    always_comb begin
        na_x = a_x;
        na_y = a_y;
        nb_x = b_x;
        nb_y = b_y;
        if (dec_mode) begin
            na_x = a_y;
            na_y = a_x ^ f_mix(a_y) ^ rk;
            nb_x = b_y;
            nb_y = b_x ^ f_mix(b_y) ^ rk;
        end else begin
            na_x = a_y ^ f_mix(a_x) ^ rk;
            na_y = a_x;
            nb_x = b_y ^ f_mix(b_x) ^ rk;
            nb_y = b_x;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (accept_new) begin
            ktab[0] <= frame_data[31:0];
            ktab[1] <= frame_data[63:32];
            ktab[2] <= frame_data[95:64];
        end else if (state == KEXP) begin
            ktab[kidx] <= knext;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame_ready  <= 1'b1;
            result_valid <= 1'b0;
            result_data  <= '0;
            busy         <= 1'b0;
            key_reg      <= '0;
            key_cached   <= 1'b0;
            dec_mode     <= 1'b0;
            a_x          <= '0;
            a_y          <= '0;
            b_x          <= '0;
            b_y          <= '0;
            w0           <= '0;
            w1           <= '0;
            w2           <= '0;
            kidx         <= '0;
            ridx         <= '0;
            rcnt         <= '0;
            rk           <= '0;
            primed       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_x         <= frame_data[159:128];
                        a_y         <= frame_data[127:96];
                        b_x         <= frame_data[223:192];
                        b_y         <= frame_data[191:160];
                        dec_mode    <= decrypt;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (key_hit) begin
                            state  <= RUN;
                            ridx   <= decrypt ? LAST : '0;
                            rcnt   <= '0;
                            primed <= 1'b0;
                        end else begin
                            key_reg    <= frame_data[95:0];
                            key_cached <= 1'b0;
                            w0         <= frame_data[31:0];
                            w1         <= frame_data[63:32];
                            w2         <= frame_data[95:64];
                            kidx       <= FIRST_EXP;
                            state      <= KEXP;
                        end
                    end
                end

                KEXP: begin
                    w0 <= w1;
                    w1 <= w2;
                    w2 <= knext;
                    if (kidx == LAST) begin
                        key_cached <= 1'b1;
                        state      <= RUN;
                        ridx       <= dec_mode ? LAST : '0;
                        rcnt       <= '0;
                        primed     <= 1'b0;
                    end else begin
                        kidx <= kidx + 1'b1;
                    end
                end

                // First RUN cycle only fetches the opening round key; each
                // later cycle applies a round while prefetching the next key.
                RUN: begin
                    rk     <= ktab[ridx];
                    primed <= 1'b1;
                    if (dec_mode) begin
                        if (ridx != '0) ridx <= ridx - 1'b1;
                    end else begin
                        if (ridx != LAST) ridx <= ridx + 1'b1;
                    end
                    if (primed) begin
                        a_x <= na_x;
                        a_y <= na_y;
                        b_x <= nb_x;
                        b_y <= nb_y;
                        if (rcnt == LAST) begin
                            result_data  <= {nb_x, nb_y, na_x, na_y};
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        frame_ready  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    frame_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_iter_ctrl.sv
// Scoreboard bench for simon_iter_ctrl: a driver issues frames and queues the
// expected result and latency; a monitor checks each result as it appears.
module tb_simon_iter_ctrl;

    logic         clk_100MHz = 1'b0;
    logic         reset;
    logic         frame_valid;
    logic         frame_ready;
    logic [255:0] frame_data;
    logic         decrypt;
    logic         result_valid;
    logic         result_ready;
    logic [127:0] result_data;
    logic         busy;

    simon_iter_ctrl #(.ROUNDS(42), .WORD(32)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .decrypt     (decrypt),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_data (result_data),
        .busy        (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        int           lat;
        int           acc;
        int           hold;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          hs_cycle = -1;
    bit          model_valid = 1'b0;
    logic [95:0] model_key = '0;

    function automatic logic [31:0] fref(input logic [31:0] v);
        return ({v[30:0], v[31]} & {v[23:0], v[31:24]}) ^ {v[29:0], v[31:30]};
    endfunction

    // Straight from the algorithm definition: full schedule, then 42 rounds
    function automatic logic [63:0] simon_ref(input logic [95:0] key, input logic [63:0] blk,
                                              input bit dec);
        string       zs = "10101111011100000011010010011000101000010001111110010110110011";
        logic [31:0] k [42];
        logic [31:0] x, y, t;
        k[0] = key[31:0];
        k[1] = key[63:32];
        k[2] = key[95:64];
        for (int i = 3; i < 42; i++) begin
            t    = {k[i-1][2:0], k[i-1][31:3]} ^ {k[i-1][3:0], k[i-1][31:4]};
            k[i] = 32'hFFFF_FFFC ^ ((zs[i-3] == 8'h31) ? 32'd1 : 32'd0) ^ k[i-3] ^ t;
        end
        x = blk[63:32];
        y = blk[31:0];
        if (!dec) begin
            for (int i = 0; i < 42; i++) begin
                t = x;
                x = y ^ fref(x) ^ k[i];
                y = t;
            end
        end else begin
            for (int i = 41; i >= 0; i--) begin
                t = y;
                y = x ^ fref(y) ^ k[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [95:0] key, input logic [63:0] a, input logic [63:0] b,
                         input bit dec, input logic [127:0] exp, input bit push,
                         input int hold, output int acc);
        int   n = 0;
        exp_t e;
        @(negedge clk_100MHz);
        frame_valid = 1'b1;
        frame_data  = {$urandom, b, a, key};
        decrypt     = dec;
        while (!frame_ready && n < 400) begin
            @(negedge clk_100MHz);
            n++;
        end
        if (!frame_ready) begin
            check("accept_timeout", 128'(frame_ready), 128'(1));
            frame_valid = 1'b0;
            acc = -1;
            return;
        end
        acc    = cyc + 1;
        e.data = exp;
        e.lat  = (model_valid && model_key == key) ? 43 : 82;
        e.acc  = acc;
        e.hold = hold;
        model_valid = 1'b1;
        model_key   = key;
        if (push) sb.push_back(e);
        @(posedge clk_100MHz);
        #1;
        check("busy_after_accept", 128'(busy), 128'(1));
        check("frame_ready_after_accept", 128'(frame_ready), 128'(0));
        @(negedge clk_100MHz);
        frame_valid = 1'b0;
        frame_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        decrypt     = 1'(~dec);
    endtask

    // Monitor: pops on each rising result_valid, then completes the handshake
    initial begin
        exp_t e;
        bit   prev = 1'b0;
        int   bad;
        result_ready = 1'b0;
        forever begin
            @(negedge clk_100MHz);
            if (result_valid && !prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_result_valid", 128'(result_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("result_data", result_data, e.data);
                    check("latency", 128'(cyc - e.acc), 128'(e.lat));
                    bad = 0;
                    for (int i = 0; i < e.hold; i++) begin
                        @(negedge clk_100MHz);
                        if (result_data !== e.data || result_valid !== 1'b1 || frame_ready !== 1'b0)
                            bad++;
                    end
                    if (e.hold > 0) check("backpressure_bad_cycles", 128'(bad), 128'(0));
                end
                result_ready = 1'b1;
                hs_cycle     = cyc + 1;
                @(negedge clk_100MHz);
                result_ready = 1'b0;
                check("valid_after_handshake", 128'(result_valid), 128'(0));
                check("ready_after_handshake", 128'(frame_ready), 128'(1));
            end
            prev = result_valid;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        int          acc;
        int          n;
        logic [95:0] k;
        logic [95:0] k2;
        logic [63:0] a, b, ca, cb;

        reset       = 1'b1;
        frame_valid = 1'b0;
        frame_data  = '0;
        decrypt     = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        check("reset_frame_ready", 128'(frame_ready), 128'(1));
        check("reset_result_valid", 128'(result_valid), 128'(0));
        check("reset_result_data", result_data, 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        reset = 1'b0;

        // Published SIMON64/96 vector, then decrypt under the cached key
        k = 96'h1312_1110_0b0a_0908_0302_0100;
        a = 64'h6f72_2067_6e69_6c63;
        issue(k, a, a, 1'b0, {64'h5ca2_e27f_111a_8fc8, 64'h5ca2_e27f_111a_8fc8}, 1'b1, 0, acc);
        issue(k, 64'h5ca2_e27f_111a_8fc8, 64'h0, 1'b1, {simon_ref(k, 64'h0, 1'b1), a}, 1'b1, 0, acc);

        // Random round trips
        repeat (20) begin
            k  = {$urandom, $urandom, $urandom};
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            ca = simon_ref(k, a, 1'b0);
            cb = simon_ref(k, b, 1'b0);
            issue(k, a, b, 1'b0, {cb, ca}, 1'b1, 0, acc);
            issue(k, ca, cb, 1'b1, {b, a}, 1'b1, 0, acc);
        end

        // Backpressure with the next frame already waiting
        k  = {$urandom, $urandom, $urandom};
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        issue(k, a, b, 1'b0, {simon_ref(k, b, 1'b0), simon_ref(k, a, 1'b0)}, 1'b1, 100, acc);
        k2 = {$urandom, $urandom, $urandom};
        issue(k2, b, a, 1'b0, {simon_ref(k2, a, 1'b0), simon_ref(k2, b, 1'b0)}, 1'b1, 0, acc);
        check("b2b_accept_cycle", 128'(acc), 128'(hs_cycle + 1));

        // Inputs churn after accept; results must reflect the accepted values
        k  = {$urandom, $urandom, $urandom};
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        ca = simon_ref(k, a, 1'b0);
        cb = simon_ref(k, b, 1'b0);
        issue(k, a, b, 1'b0, {cb, ca}, 1'b1, 0, acc);
        repeat (90) begin
            @(negedge clk_100MHz);
            frame_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            decrypt    = ~decrypt;
        end
        issue(k, ca, cb, 1'b1, {b, a}, 1'b1, 0, acc);
        repeat (50) begin
            @(negedge clk_100MHz);
            frame_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            decrypt    = ~decrypt;
        end

        // Reset during key expansion
        k = {$urandom, $urandom, $urandom};
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        issue(k, a, b, 1'b0, '0, 1'b0, 0, acc);
        repeat (19) @(negedge clk_100MHz);
        reset       = 1'b1;
        model_valid = 1'b0;
        #1;
        check("kexp_reset_frame_ready", 128'(frame_ready), 128'(1));
        check("kexp_reset_busy", 128'(busy), 128'(0));
        @(negedge clk_100MHz);
        reset = 1'b0;
        issue(k, a, b, 1'b0, {simon_ref(k, b, 1'b0), simon_ref(k, a, 1'b0)}, 1'b1, 0, acc);

        // Reset during rounds on a cached key
        issue(k, b, a, 1'b1, '0, 1'b0, 0, acc);
        repeat (19) @(negedge clk_100MHz);
        reset       = 1'b1;
        model_valid = 1'b0;
        #1;
        check("run_reset_frame_ready", 128'(frame_ready), 128'(1));
        check("run_reset_result_valid", 128'(result_valid), 128'(0));
        @(negedge clk_100MHz);
        reset = 1'b0;
        issue(k, b, a, 1'b1, {simon_ref(k, a, 1'b1), simon_ref(k, b, 1'b1)}, 1'b1, 0, acc);

        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk_100MHz);
            n++;
        end
        if (sb.size() != 0) check("scoreboard_drain", 128'(sb.size()), 128'(0));
        repeat (5) @(negedge clk_100MHz);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simon_iter_ctrl.md
Name: simon_iter_ctrl

Overview:
Iterative SIMON64/96 engine and sequencer between the UART frame buffer and the UART transmit buffer.
- Accepts one 256-bit frame per transaction: 96-bit key plus two 64-bit blocks.
- Expands and caches the 42 round keys in a register table.
- Runs both blocks through one round per cycle and returns a 128-bit result under a valid/ready handshake.
- Replaces the two combinational unrolled cipher instances with a multi-cycle datapath that meets timing.

Parameters:
ROUNDS, 42, number of SIMON64/96 rounds (fixed by algorithm; not to be overridden)
WORD, 32, SIMON word width n

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous active-high reset
frame_valid  in  1  frame_data is valid
frame_ready  out  1  block can accept a frame
frame_data  in  256  [95:0] key; [159:96] block A; [223:160] block B; [255:224] ignored
decrypt  in  1  0 = encrypt, 1 = decrypt; sampled only at frame accept
result_valid  out  1  result_data is valid
result_ready  in  1  downstream accepts result
result_data  out  128  {block B out, block A out}
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - Outputs: frame_ready=1, result_valid=0, result_data=0, busy=0.
  - key_cached flag is cleared and the round-key table contents are don't-care.
  - Reset mid-operation aborts the transaction. No result is produced.
- Key words: k0=key[31:0], k1=key[63:32], k2=key[95:64].
- Key expansion, for i=3..41:
  - k[i] = 0xFFFFFFFC ^ z2[i-3] ^ k[i-3] ^ ROR3(k[i-1]) ^ ROR4(k[i-1]).
  - z2 bit string, index 0 first: 10101111011100000011010010011000101000010001111110010110110011.
- Block words: x = block[63:32], y = block[31:0].
- f(v) = (ROL1(v) & ROL8(v)) ^ ROL2(v).
- Encrypt round i=0..41: (x,y) <- (y ^ f(x) ^ k[i], x).
- Decrypt round i=41..0: (x,y) <- (y, x ^ f(y) ^ k[i]).
- Both lanes use the same k[i] in the same cycle. One round-key table read per cycle.
- FSM states:
  - IDLE:
    - frame_ready=1.
    - On frame_valid&frame_ready: latch the blocks, decrypt and the key.
    - If key_cached and the key equals the stored key: go to RUN.
    - Otherwise: store the key, write k0..k2, clear key_cached, go to KEXP.
  - KEXP:
    - One k[i] written per cycle, i=3..41 (39 cycles).
    - After k[41]: set key_cached, go to RUN.
  - RUN:
    - Round counter starts at 0 (encrypt) or 41 (decrypt).
    - One round per cycle, 42 cycles.
    - After the last round: load result_data, go to DONE.
  - DONE:
    - result_valid=1. result_data is held stable.
    - On result_ready: result_valid=0, go to IDLE.
    - Backpressure is unlimited. No frame is accepted while in DONE.
- Latency, counted from the accept edge:
  - result_valid rises 82 cycles later with a new key.
  - result_valid rises 43 cycles later with the cached key.
- frame_ready=0 in every state except IDLE. frame_valid outside IDLE is ignored; the source must hold it.
- frame_data and decrypt may change after accept without effect.
- Back-to-back: the cycle after result handshake is IDLE, so frame_ready=1 that cycle.
- A key change always triggers re-expansion. Encrypt and decrypt share the cached key table.

Test Plan:
- Encrypt, new key:
  - Stimulus: key=0x131211100b0a090803020100, A=B=0x6f7220676e696c63, decrypt=0.
  - Required: result_data=0x5ca2e27f111a8fc8_5ca2e27f111a8fc8, result_valid exactly 82 cycles after accept.
- Decrypt, cached key:
  - Stimulus: same key, A=0x5ca2e27f111a8fc8, B=0, decrypt=1.
  - Required: A out=0x6f7220676e696c63, B out = decrypt of 0 under that key; latency 43 cycles.
- Round trip:
  - Stimulus: 20 random key/block frames, each encrypted then decrypted.
  - Required: blocks restored bit-exact. Latency 82 on each key change, 43 otherwise.
- Backpressure:
  - Stimulus: hold result_ready=0 for 100 cycles while frame_valid=1 with a new frame.
  - Required: result_data stable, frame_ready=0 throughout. New frame accepted on the cycle after result_ready.
- Reset mid-RUN and mid-KEXP:
  - Stimulus: assert reset at cycle 20 of the operation.
  - Required: result_valid never rises, frame_ready=1 immediately. Next frame with the same key takes 82 cycles (cache cleared).
- Mode latch:
  - Stimulus: toggle decrypt and frame_data every cycle after accept.
  - Required: result matches the values captured at accept.
